// File: rtl/hdmi_i2c_init_sequencer.sv
// Walks a {dev, reg, data} register table and issues each entry as one I2C write,
// retrying NACKed entries and reporting the failing index when retries run out.
module hdmi_i2c_init_sequencer #(
  parameter int CLK_DIV   = 125,
  parameter int ADDR_W    = 8,
  parameter int RETRY_MAX = 3
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_index,
  output logic [ADDR_W-1:0] tbl_addr,
  input  logic [23:0]       tbl_data,
  output logic              scl,
  output logic              sda_oe,
  input  logic              sda_i
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TOP   = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       RETRY_LIM = 4'(RETRY_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_BIT, S_ACK, S_STOP, S_NEXT
  } state_t;

  typedef struct packed {
    logic [7:0] dev;
    logic [7:0] rga;
    logic [7:0] data;
  } entry_t;

  state_t            state, state_n;
  logic [1:0]        q, q_n;
  logic [2:0]        bit_cnt, bit_n;
  logic [1:0]        byte_sel, byte_n;
  entry_t            ent, ent_n;
  logic [DIV_W-1:0]  div, div_n;
  logic [3:0]        retry, retry_n;
  logic [ADDR_W-1:0] index, index_n;
  logic              nack, nack_n;
  logic              error_n, done_n, busy_n;
  logic [ADDR_W-1:0] err_index_n;
  logic              scl_n, sda_n;
  logic [1:0]        sda_sync;
  logic              sda_s, tick, bit_val;
  logic [7:0]        cur_byte;

  assign tick     = (div == '0);
  assign sda_s    = sda_sync[1];
  assign tbl_addr = index;

  always_comb begin
    cur_byte = ent.data;
    case (byte_sel)
      2'd0:    cur_byte = ent.dev;
      2'd1:    cur_byte = ent.rga;
      default: cur_byte = ent.data;
    endcase
  end
  assign bit_val = cur_byte[bit_cnt];

  // Divider is reloaded in FETCH and keeps counting through LOAD, so START Q0 is one
  // cycle short and a full entry costs exactly 2 + 113 quarters including NEXT.
  always_comb begin
    if (state == S_IDLE)
      div_n = '0;
    else if (state == S_FETCH || tick)
      div_n = DIV_TOP;
    else
      div_n = div - DIV_W'(1);
  end

  always_comb begin
    state_n     = state;
    q_n         = q;
    bit_n       = bit_cnt;
    byte_n      = byte_sel;
    ent_n       = ent;
    retry_n     = retry;
    index_n     = index;
    nack_n      = nack;
    error_n     = error;
    err_index_n = err_index;
    done_n      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          index_n = '0;
          error_n = 1'b0;
          retry_n = '0;
          state_n = S_FETCH;
        end
      end
      S_FETCH: state_n = S_LOAD;
      S_LOAD: begin
        // dev[0] is forced to the write direction at capture time
        ent_n = {tbl_data[23:16] & 8'hFE, tbl_data[15:0]};
        if (tbl_data[23:16] == 8'hFF) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else begin
          q_n     = '0;
          nack_n  = 1'b0;
          state_n = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (q == 2'd1) begin
            q_n     = '0;
            bit_n   = 3'd7;
            byte_n  = '0;
            state_n = S_BIT;
          end else begin
            q_n = q + 2'd1;
          end
        end
      end
      S_BIT: begin
        if (tick) begin
          q_n = q + 2'd1;
          if (q == 2'd3) begin
            if (bit_cnt == 3'd0) state_n = S_ACK;
            else                 bit_n   = bit_cnt - 3'd1;
          end
        end
      end
      S_ACK: begin
        if (tick) begin
          q_n = q + 2'd1;
          if (q == 2'd2 && sda_s) nack_n = 1'b1;
          if (q == 2'd3) begin
            if (nack || byte_sel == 2'd2) begin
              state_n = S_STOP;
            end else begin
              byte_n  = byte_sel + 2'd1;
              bit_n   = 3'd7;
              state_n = S_BIT;
            end
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (q == 2'd2) begin
            q_n = '0;
            if (!nack) begin
              state_n = S_NEXT;
            end else if (retry < RETRY_LIM) begin
              retry_n = retry + 4'd1;
              nack_n  = 1'b0;
              state_n = S_START;
            end else begin
              error_n     = 1'b1;
              err_index_n = index;
              state_n     = S_IDLE;
            end
          end else begin
            q_n = q + 2'd1;
          end
        end
      end
      S_NEXT: begin
        retry_n = '0;
        // last table slot acts as an implicit terminator rather than wrapping
        if (index == '1) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else begin
          index_n = index + ADDR_W'(1);
          state_n = S_FETCH;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy_n = (state_n != S_IDLE);

  always_comb begin
    scl_n = 1'b1;
    sda_n = 1'b0;
    case (state)
      S_START: sda_n = (q == 2'd1);
      S_BIT: begin
        scl_n = (q == 2'd1) || (q == 2'd2);
        sda_n = ~bit_val;
      end
      S_ACK:   scl_n = (q == 2'd1) || (q == 2'd2);
      S_STOP: begin
        scl_n = (q != 2'd0);
        sda_n = (q != 2'd2);
      end
      default: begin
        scl_n = 1'b1;
        sda_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      q         <= '0;
      bit_cnt   <= '0;
      byte_sel  <= '0;
      ent       <= '0;
      div       <= '0;
      retry     <= '0;
      index     <= '0;
      nack      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_index <= '0;
      scl       <= 1'b1;
      sda_oe    <= 1'b0;
      sda_sync  <= 2'b11;
    end else begin
      state     <= state_n;
      q         <= q_n;
      bit_cnt   <= bit_n;
      byte_sel  <= byte_n;
      ent       <= ent_n;
      div       <= div_n;
      retry     <= retry_n;
      index     <= index_n;
      nack      <= nack_n;
      busy      <= busy_n;
      done      <= done_n;
      error     <= error_n;
      err_index <= err_index_n;
      scl       <= scl_n;
      sda_oe    <= sda_n;
      sda_sync  <= {sda_sync[0], sda_i};
    end
  end

endmodule
